// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if -- instruction-memory request/response bundle.
//   imem_req  : fetch unit -> memory, request valid
//   imem_addr : fetch unit -> memory, word address of the request
//   imem_ack  : memory -> fetch unit, imem_data is valid this cycle
//   imem_data : memory -> fetch unit, returned instruction word
// master = fetch unit side, slave = memory side.
// -----------------------------------------------------------------------------
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- instruction fetch stage with a 2-entry {I, PC, nPC} buffer.
//   clk         : single clock, rising edge
//   reset       : synchronous, active-high
//   stall       : decode is holding; the head entry is not consumed
//   redirect    : taken branch/call/jmpl; flush the buffer and refetch
//   redirect_pc : redirect target (low two bits ignored)
//   imem        : instruction-memory port (master side of fetch_unit_if)
//   valid_out   : I_out/PC_out/nPC_out hold a valid instruction
//   I_out       : head instruction
//   PC_out      : head instruction address
//   nPC_out     : PC_out + 4
// At most one memory request is outstanding. A redirect that arrives while a
// request is still waiting for its ack moves to DROP, which keeps the old
// request on the bus until it completes and throws its data away.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  fetch_unit_if.master imem,
  output logic         valid_out,
  output logic [31:0]  I_out,
  output logic [31:0]  PC_out,
  output logic [31:0]  nPC_out
);

  typedef enum logic {FETCH, DROP} state_t;

  typedef struct packed {
    logic [31:0] i;
    logic [31:0] pc;
    logic [31:0] npc;
  } entry_t;

  state_t      r_state,    w_state_nxt;
  logic [31:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [31:0] r_redir_pc, w_redir_pc_nxt;   // pending target while in DROP
  logic [1:0]  r_count;
  entry_t      r_fifo [2];                   // r_fifo[0] is the head

  logic        w_req;
  logic        w_enq;
  logic        w_deq;
  logic [31:0] w_redir_aligned;
  logic [31:0] w_pc_plus4;
  entry_t      w_new_entry;

  assign w_redir_aligned = {redirect_pc[31:2], 2'b00};
  assign w_pc_plus4      = r_fetch_pc + 32'd4;   // wraps modulo 2^32
  assign w_new_entry     = '{i: imem.imem_data, pc: r_fetch_pc, npc: w_pc_plus4};

  assign valid_out = (r_count != 2'd0);
  assign I_out     = r_fifo[0].i;
  assign PC_out    = r_fifo[0].pc;
  assign nPC_out   = r_fifo[0].npc;

  // Redirect outranks both stall and dequeue.
  assign w_deq = valid_out && !stall && !redirect;

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_fetch_pc;

  // NOTE: every signal driven here gets a default first so no latch is
  // inferred on paths that do not assign it.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_redir_pc_nxt = r_redir_pc;
    w_req          = 1'b0;
    w_enq          = 1'b0;
    case (r_state)
      FETCH: begin
        // Full buffer may still request when the head leaves this cycle.
        w_req = (r_count < 2'd2) || w_deq;
        if (redirect) begin
          if (w_req && !imem.imem_ack) begin
            // Request is in flight: it must complete on the old address.
            w_state_nxt    = DROP;
            w_redir_pc_nxt = w_redir_aligned;
          end else begin
            // No request, or its data arrives now and is discarded.
            w_fetch_pc_nxt = w_redir_aligned;
          end
        end else if (w_req && imem.imem_ack) begin
          w_enq          = 1'b1;
          w_fetch_pc_nxt = w_pc_plus4;
        end
      end
      DROP: begin
        w_req = 1'b1;
        if (imem.imem_ack) begin
          w_state_nxt    = FETCH;
          w_fetch_pc_nxt = redirect ? w_redir_aligned : r_redir_pc;
        end else if (redirect) begin
          w_redir_pc_nxt = w_redir_aligned;
        end
      end
      default: w_state_nxt = FETCH;
    endcase
    // Any request (and so any ack) is ignored while reset is high.
    if (reset) begin
      w_req = 1'b0;
      w_enq = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FETCH;
      r_fetch_pc <= RESET_PC;
      r_redir_pc <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_redir_pc <= w_redir_pc_nxt;
    end
  end

  // NOTE: the buffer payloads are cleared on reset so the outputs are defined
  // zeros rather than stale data; this is cheap at two entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 2'd0;
      for (int k = 0; k < 2; k++) r_fifo[k] <= '0;
    end else if (redirect) begin
      r_count <= 2'd0;
    end else begin
      case ({w_deq, w_enq})
        2'b10: begin
          r_fifo[0] <= r_fifo[1];
          r_count   <= r_count - 2'd1;
        end
        2'b01: begin
          // Enqueue alone only happens with count 0 or 1.
          r_fifo[r_count[0]] <= w_new_entry;
          r_count            <= r_count + 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_fifo[0] <= w_new_entry;
          end else begin
            r_fifo[0] <= r_fifo[1];
            r_fifo[1] <= w_new_entry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit -- self-checking bench for fetch_unit.
// The reference model keeps the instruction buffer as a queue, the next fetch
// address, and a "dropping" flag with its pending target. Directed sequences
// cover the reset, stall, ack-delay, redirect and address-wrap cases; a long
// randomized phase follows. A second instance runs with RESET_PC=FFFF_FFFC.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic        valid_out;
  logic [31:0] I_out, PC_out, nPC_out;

  logic        stall2, redirect2;
  logic [31:0] redirect_pc2;
  logic        valid_out2;
  logic [31:0] I_out2, PC_out2, nPC_out2;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit_if imem ();
  fetch_unit_if imem2 ();

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem(imem.master), .valid_out(valid_out),
    .I_out(I_out), .PC_out(PC_out), .nPC_out(nPC_out)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .stall(stall2), .redirect(redirect2),
    .redirect_pc(redirect_pc2), .imem(imem2.master), .valid_out(valid_out2),
    .I_out(I_out2), .PC_out(PC_out2), .nPC_out(nPC_out2)
  );

  // Zero-wait memory for the wrap instance; data derived from the address.
  assign imem2.imem_data = ~imem2.imem_addr;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] i;
    logic [31:0] pc;
    logic [31:0] npc;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_drop;
  logic [31:0] m_tgt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, check, advance model.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input logic ak);
    bit          exp_deq, exp_req, acked;
    logic [31:0] tgt;
    @(negedge clk);
    reset          = 1'b0;
    stall          = st;
    redirect       = rd;
    redirect_pc    = rpc;
    imem.imem_ack  = ak;
    imem.imem_data = $urandom;
    #1;
    exp_deq = (m_q.size() != 0) && !st && !rd;
    exp_req = m_drop || (m_q.size() < 2) || exp_deq;
    acked   = exp_req && ak;
    tgt     = {rpc[31:2], 2'b00};

    check("imem_req", {31'd0, imem.imem_req}, {31'd0, exp_req});
    if (exp_req) check("imem_addr", imem.imem_addr, m_pc);
    check("valid_out", {31'd0, valid_out}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      check("I_out",   I_out,   m_q[0].i);
      check("PC_out",  PC_out,  m_q[0].pc);
      check("nPC_out", nPC_out, m_q[0].npc);
    end

    if (m_drop) begin
      if (acked) begin
        m_drop = 0;
        m_pc   = rd ? tgt : m_tgt;
      end else if (rd) begin
        m_tgt = tgt;
      end
      if (rd) m_q.delete();
    end else if (rd) begin
      m_q.delete();
      if (exp_req && !ak) begin
        m_drop = 1;
        m_tgt  = tgt;
      end else begin
        m_pc = tgt;
      end
    end else begin
      if (exp_deq) void'(m_q.pop_front());
      if (acked) begin
        m_q.push_back('{i: imem.imem_data, pc: m_pc, npc: m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Hold reset for n cycles with the memory acking; outputs must stay idle.
  task automatic do_reset(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      reset          = 1'b1;
      stall          = 1'b0;
      redirect       = 1'b0;
      imem.imem_ack  = 1'b1;
      imem.imem_data = $urandom;
      #1;
      check("rst_req", {31'd0, imem.imem_req}, 32'd0);
      if (c > 0) check("rst_valid", {31'd0, valid_out}, 32'd0);
    end
    m_q.delete();
    m_pc   = 32'h0;
    m_drop = 0;
    m_tgt  = 32'h0;
  endtask

  initial begin
    reset           = 1'b1;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = '0;
    imem.imem_ack   = 1'b0;
    imem.imem_data  = '0;
    stall2          = 1'b0;
    redirect2       = 1'b0;
    redirect_pc2    = '0;
    imem2.imem_ack  = 1'b1;

    // Streaming from reset: PC 0,4,8,12 with valid from the 2nd cycle;
    // wrap instance shows FFFF_FFFC then 0.
    do_reset(3);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      if (k == 0) begin
        check("stream_first_addr", imem.imem_addr, 32'h0);
        check("stream_first_valid", {31'd0, valid_out}, 32'd0);
      end else begin
        check("stream_pc",  PC_out,  32'(k - 1) * 32'd4);
        check("stream_npc", nPC_out, 32'(k - 1) * 32'd4 + 32'd4);
      end
      if (k == 1) begin
        check("wrap_pc0",  PC_out2,  32'hFFFF_FFFC);
        check("wrap_npc0", nPC_out2, 32'h0000_0000);
      end
      if (k == 2) check("wrap_pc1", PC_out2, 32'h0000_0000);
    end

    // Stall 3 cycles with ack=1: buffer fills, request drops, head frozen.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'h0, 1'b1);
    check("stall_full_req", {31'd0, imem.imem_req}, 32'd0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Delayed ack on address 8, then redirect to 0x40 while 0x10 pends.
    do_reset(2);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      check("wait_addr8", imem.imem_addr, 32'h8);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h40, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check("drop_old_addr", imem.imem_addr, 32'h10);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("drop_new_addr", imem.imem_addr, 32'h40);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("drop_first_pc", PC_out, 32'h40);

    // Redirect with an unaligned target in the same cycle as an ack.
    step(1'b0, 1'b1, 32'h103, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("redir_ack_addr",  imem.imem_addr, 32'h100);
    check("redir_ack_valid", {31'd0, valid_out}, 32'd0);

    // Randomized traffic, with one reset landing in the middle.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset(2);
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0,
           $urandom, $urandom_range(0, 9) < 6);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
